// File: rtl/moore_sequence_generator.sv
`default_nettype none
//============================================================================
// Module      : moore_sequence_generator
// Description : Serial pattern transmitter built as a three-state Moore FSM.
//               A start request in IDLE captures a bit pattern, its length
//               and a repetition count. The pattern is then shifted out
//               MSB-first, from bit len-1 down to bit 0. Repetitions follow
//               each other with no gap. A one-cycle done pulse follows the
//               final bit.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   MAX_LEN  maximum pattern length in bits (default 16)
// Ports
//   clk      input   1        rising-edge clock
//   reset    input   1        synchronous active-low reset
//   start    input   1        begin transmission (sampled in IDLE only)
//   pattern  input   MAX_LEN  pattern to send, MSB-first from bit len-1
//   len      input   5        length in bits; 0 = invalid, >MAX_LEN clamps
//   reps     input   4        repetition count; 0 is treated as 1
//   out      output  1        serial data bit (registered)
//   valid    output  1        out carries a pattern bit
//   busy     output  1        FSM is outside IDLE
//   done     output  1        one-cycle pulse after the final bit
//============================================================================
module moore_sequence_generator #(
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [4:0]         len,
    input  logic [3:0]         reps,
    output logic               out,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    // Index counter width; a one-bit pattern still needs a one-bit index.
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    logic [MAX_LEN-1:0]   pattern_q;
    logic [IDX_W-1:0]     len_m1_q;     // captured (clamped length - 1)
    logic [IDX_W-1:0]     idx_q;        // bit currently on out
    logic [3:0]           reps_left_q;  // repetitions still to follow
    logic                 out_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;

    // Values loaded on the capturing edge.
    logic [IDX_W-1:0]     len_m1_d;
    logic [3:0]           reps_left_d;
    logic                 start_ok_d;

    // The length is held as (len - 1) so that it fits the index width
    // even when len equals MAX_LEN; anything at or above MAX_LEN clamps.
    always_comb begin
        len_m1_d = IDX_W'(MAX_LEN - 1);
        if ((len != 5'd0) && (int'(len) < MAX_LEN)) begin
            len_m1_d = IDX_W'(int'(len) - 1);
        end
        // reps = 0 behaves like 1, i.e. no further repetitions after the first.
        reps_left_d = (reps == 4'd0) ? 4'd0 : (reps - 4'd1);
        start_ok_d  = start && (len != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            len_m1_q    <= '0;
            idx_q       <= '0;
            reps_left_q <= 4'd0;
            out_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok_d) begin
                        state_q     <= SHIFT;
                        pattern_q   <= pattern;
                        len_m1_q    <= len_m1_d;
                        idx_q       <= len_m1_d;
                        reps_left_q <= reps_left_d;
                        // First bit is presented straight from the inputs
                        // so it appears one clock after start.
                        out_q       <= pattern[len_m1_d];
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (idx_q == '0) begin
                        if (reps_left_q != 4'd0) begin
                            // Wrap to the top bit without an idle slot.
                            reps_left_q <= reps_left_q - 4'd1;
                            idx_q       <= len_m1_q;
                            out_q       <= pattern_q[len_m1_q];
                        end else begin
                            state_q <= DONE;
                            out_q   <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                        out_q <= pattern_q[idx_q - IDX_W'(1)];
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: doc/moore_sequence_generator.md
MOORE_SEQUENCE_GENERATOR -- requirements
Module: moore_sequence_generator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MAX_LEN  16  maximum pattern length in bits
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all state changes on its rising edge
  reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
  start  input  1  request to begin transmission; sampled in IDLE only
  pattern  input  MAX_LEN  bit pattern to transmit; MSB-first from bit len-1
  len  input  5  pattern length in bits; 0 = invalid, values above MAX_LEN clamp to MAX_LEN
  reps  input  4  repetition count; 0 is treated as 1
  out  output  1  serial data bit; registered Moore output
  valid  output  1  out carries a pattern bit this cycle
  busy  output  1  high in any state other than IDLE
  done  output  1  one-cycle pulse after the final bit

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE; all outputs SHALL be decoded from registered state only (Moore, no combinational input-to-output path).
REQ-004 IDLE -> SHIFT SHALL occur on the edge where start=1 and len!=0; that edge SHALL capture pattern, the clamped len and the adjusted reps into internal registers.
REQ-005 In IDLE, start=1 with len=0 SHALL be ignored: state stays IDLE and no register changes.
REQ-006 After the capturing edge, out SHALL be pattern[len-1] and valid=1 (latency: one clock from start to first bit).
REQ-007 Each subsequent edge in SHIFT SHALL advance out to the next lower bit; after bit 0, the next edge SHALL wrap to bit len-1 if repetitions remain.
REQ-008 Repetitions SHALL be contiguous, with no idle bit between them; total valid cycles SHALL equal len*reps.
REQ-009 The edge after bit 0 of the last repetition SHALL move the FSM to DONE: done=1, valid=0, out=0, busy=1.
REQ-010 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-011 start SHALL be ignored in SHIFT and DONE; input changes to pattern, len or reps after capture SHALL have no effect on the transmission in progress.
REQ-012 In IDLE, the outputs SHALL be out=0, valid=0, busy=0, done=0.
REQ-013 The bit index counter SHALL be ceil(log2(MAX_LEN)) bits wide and the repetition counter 4 bits wide; neither SHALL underflow or wrap outside the ranges above.

Reset
REQ-014 On any rising edge with reset=0, the FSM SHALL enter IDLE, clear all counters and captured registers, and drive out=0, valid=0, busy=0, done=0.
REQ-015 Reset SHALL take priority over start and over any in-progress transmission; a mid-operation reset SHALL abort without generating a done pulse.
REQ-016 The first edge with reset=1 SHALL behave as a normal IDLE cycle, so start may be accepted on that edge.

Verification
REQ-017 Basic pattern: pattern=16'h000A, len=4, reps=1, start pulse -> out=1,0,1,0 with valid=1 for 4 cycles, then done=1 for 1 cycle, then IDLE.
REQ-018 Repeated pattern: pattern=16'h000A, len=4, reps=3 -> 12 contiguous valid bits 101010101010, a single done pulse, and busy high for 13 cycles.
REQ-019 Boundary values: len=0 with start -> busy stays 0; len=20 with pattern=16'h8001, reps=0 -> 16 bits 1000000000000001, then done.
REQ-020 Busy-time inputs: start re-asserted and pattern changed during SHIFT -> original sequence unaltered; a new start is accepted only once the FSM is back in IDLE.
REQ-021 Reset mid-operation: reset=0 on the third bit of a len=8 transmission -> next cycle out=0, valid=0, busy=0, done=0, with no done pulse.
REQ-022 Loopback: out fed to the team's Moore sequence detector, pattern=1010, reps=3 -> detector asserts its output at the expected overlapping positions.
